// File: rtl/button_conditioner.sv
// Debounces N active-low push-buttons into an active-high level plus one-cycle press and
// release pulses, after a 2-flop synchronizer and a per-channel 4-state debounce FSM.
module button_conditioner #(
  parameter int unsigned N         = 2,
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned CW        = 20
) (
  input  logic         Clk,
  input  logic         reset_n,
  input  logic [N-1:0] button,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release
);

  typedef enum logic [1:0] {
    StReleased,
    StPressPend,
    StPressed,
    StRelPend
  } state_e;

  localparam logic [CW-1:0] CntMax = CW'(DB_CYCLES - 1);

  logic [N-1:0]  sync1_q, sync2_q;
  state_e        state_q [N];
  state_e        state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [N-1:0]  level_q, level_d;
  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  release_q, release_d;

  // Synchronizer idles at 1 so reset reads as "released".
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        StReleased: begin
          if (!sync2_q[i]) begin
            state_d[i] = StPressPend;
            cnt_d[i]   = '0;
          end
        end
        StPressPend: begin
          if (sync2_q[i]) begin
            state_d[i] = StReleased;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StPressed;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        StPressed: begin
          if (sync2_q[i]) begin
            state_d[i] = StRelPend;
            cnt_d[i]   = '0;
          end
        end
        StRelPend: begin
          if (!sync2_q[i]) begin
            state_d[i] = StPressed;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StReleased;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = StReleased;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so level and pulse rise on the same edge.
  always_comb begin
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      level_d[i]   = (state_d[i] == StPressed) || (state_d[i] == StRelPend);
      press_d[i]   = (state_q[i] == StPressPend) && (state_d[i] == StPressed);
      release_d[i] = (state_q[i] == StRelPend) && (state_d[i] == StReleased);
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N); i++) begin
        state_q[i] <= StReleased;
        cnt_q[i]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with N=2, DB_CYCLES=4: stimulus queues the expected
// pulse events, a monitor pops and checks them whenever a pulse appears.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] button = 2'b11;
  logic [1:0] btn_level, btn_press, btn_release;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  press;
    logic [1:0]  rel;
    logic [1:0]  level;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  button_conditioner #(
    .N(2),
    .DB_CYCLES(4),
    .CW(2)
  ) dut (
    .Clk(clk),
    .reset_n(reset_n),
    .button(button),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Monitor: counts edges, checks every observed pulse against the queue head.
  always @(posedge clk) begin
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      tests++;
      fails++;
      $display("FAIL missing_pulse: expected at cycle %0d press=%b rel=%b, not observed",
               sb[0].cyc, sb[0].press, sb[0].rel);
      void'(sb.pop_front());
    end
    if ((btn_press | btn_release) != 2'b00) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: cycle %0d press=%b rel=%b level=%b, required none",
                 cyc, btn_press, btn_release, btn_level);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || btn_press !== e.press || btn_release !== e.rel ||
            btn_level !== e.level) begin
          fails++;
          $display("FAIL pulse: got cycle %0d press=%b rel=%b level=%b, required cycle %0d press=%b rel=%b level=%b",
                   cyc, btn_press, btn_release, btn_level, e.cyc, e.press, e.rel, e.level);
        end
      end
    end
  end

  // Called just after a negedge: the change lands 2 + DB_CYCLES + 1 = 7 edges later.
  task automatic expect_event(input logic [1:0] press, input logic [1:0] rel,
                              input logic [1:0] level);
    exp_t e;
    e.cyc   = cyc + 7;
    e.press = press;
    e.rel   = rel;
    e.level = level;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_level(input string name, input logic [1:0] exp);
    tests++;
    if (btn_level !== exp) begin
      fails++;
      $display("FAIL %s: btn_level=%b, required %b", name, btn_level, exp);
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({btn_level, btn_press, btn_release} !== 6'b0) begin
      fails++;
      $display("FAIL %s: level=%b press=%b rel=%b, required all 0",
               name, btn_level, btn_press, btn_release);
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #11 check_zero("reset_outputs");
    @(negedge clk);
    reset_n = 1'b1;
    wait_cyc(3);
    check_level("idle_level", 2'b00);

    // Clean press then clean release on channel 0.
    button = 2'b10;
    expect_event(2'b01, 2'b00, 2'b01);
    wait_cyc(10);
    check_level("press0_level", 2'b01);
    button = 2'b11;
    expect_event(2'b00, 2'b01, 2'b00);
    wait_cyc(10);
    check_level("release0_level", 2'b00);

    // Short low glitch: rejected.
    button = 2'b10;
    wait_cyc(3);
    button = 2'b11;
    wait_cyc(10);
    check_level("press_glitch_level", 2'b00);

    // Press, short high glitch, stays pressed; then clean release.
    button = 2'b10;
    expect_event(2'b01, 2'b00, 2'b01);
    wait_cyc(10);
    button = 2'b11;
    wait_cyc(2);
    button = 2'b10;
    wait_cyc(10);
    check_level("release_glitch_level", 2'b01);
    button = 2'b11;
    expect_event(2'b00, 2'b01, 2'b00);
    wait_cyc(10);

    // Both channels together.
    button = 2'b00;
    expect_event(2'b11, 2'b00, 2'b11);
    wait_cyc(10);
    check_level("both_press_level", 2'b11);
    button = 2'b11;
    expect_event(2'b00, 2'b11, 2'b00);
    wait_cyc(10);
    check_level("both_release_level", 2'b00);

    // Reset in the middle of a pending press; button held low restarts the press.
    button = 2'b10;
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("reset_mid_pending");
    @(negedge clk);
    reset_n = 1'b1;
    expect_event(2'b01, 2'b00, 2'b01);
    wait_cyc(10);
    check_level("press_after_reset_level", 2'b01);

    // Reset during a press pulse on channel 1 aborts everything at once.
    button = 2'b00;
    expect_event(2'b10, 2'b00, 2'b11);
    repeat (7) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_zero("reset_mid_pulse");
    @(negedge clk);
    reset_n = 1'b1;
    expect_event(2'b11, 2'b00, 2'b11);
    wait_cyc(10);
    button = 2'b11;
    expect_event(2'b00, 2'b11, 2'b00);
    wait_cyc(10);
    check_level("final_level", 2'b00);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d events left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
